uart_rx_byte: RTL and testbench

- Serial UART receiver; the receive-side counterpart to the uart_tx_byte transmitter.
- Frame format: 8N1, LSB first. A build macro adds an even-parity bit.
- Synchronises the asynchronous rx line, detects the start bit and samples each bit at its centre.
- Presents each received byte with a one-cycle strobe; flags framing and parity errors.
- Sits between the board serial pin and the byte consumer (command parser / FIFO).

---
 rtl/uart_rx_byte.sv | 144 ++++++++++++++
 tb/tb_uart_rx_byte.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop rx synchroniser, mid-bit sampling, one-cycle result strobes.
// Build macro UART_RX_PARITY_EN inserts an even-parity bit between bit 7 and the stop bit.
module uart_rx_byte #(
  parameter int CLK_PER_BIT = 434,
  parameter int CTR_SIZE    = $clog2(CLK_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       new_data,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd4;
  localparam logic [2:0] WAIT_HIGH = 3'd5;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY    = 3'd3;
`endif

  localparam logic [CTR_SIZE-1:0] CTR_BIT  = CTR_SIZE'(CLK_PER_BIT - 1);
  localparam logic [CTR_SIZE-1:0] CTR_HALF = CTR_SIZE'(CLK_PER_BIT / 2 - 1);

  logic [2:0]          state;
  logic [CTR_SIZE-1:0] ctr;
  logic [2:0]          bit_idx;
  logic [7:0]          shreg;
  logic                rx_meta, rxs;
`ifdef UART_RX_PARITY_EN
  logic                par_bad;
`else
  assign parity_err = 1'b0;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // Preset high so reset release never looks like a start bit
      rx_meta   <= 1'b1;
      rxs       <= 1'b1;
      state     <= IDLE;
      ctr       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= 8'h00;
      new_data  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_meta   <= rx;
      rxs       <= rx_meta;
      new_data  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            ctr   <= '0;
          end
        end
        START: begin
          if (ctr == CTR_HALF) begin
            ctr     <= '0;
            bit_idx <= '0;
            // Line back high at mid start bit: treat as a glitch
            state   <= rxs ? IDLE : DATA;
          end else begin
            ctr <= ctr + 1'b1;
          end
        end
        DATA: begin
          if (ctr == CTR_BIT) begin
            ctr            <= '0;
            shreg[bit_idx] <= rxs;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            ctr <= ctr + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (ctr == CTR_BIT) begin
            ctr     <= '0;
            par_bad <= ^{shreg, rxs};
            state   <= STOP;
          end else begin
            ctr <= ctr + 1'b1;
          end
        end
`endif
        STOP: begin
          if (ctr == CTR_BIT) begin
            ctr <= '0;
            // Leaving at mid stop bit lets a back-to-back start bit be caught
            if (!rxs) begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end else begin
              state <= IDLE;
`ifdef UART_RX_PARITY_EN
              if (par_bad) begin
                parity_err <= 1'b1;
              end else begin
                data     <= shreg;
                new_data <= 1'b1;
              end
`else
              data     <= shreg;
              new_data <= 1'b1;
`endif
            end
          end else begin
            ctr <= ctr + 1'b1;
          end
        end
        WAIT_HIGH: begin
          // A held-low line must not retrigger a start
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Randomised bench for uart_rx_byte: frames are predicted from the framing rules
// (byte, parity, stop bit) and compared with the strobes seen on the outputs.
module tb_uart_rx_byte;
  localparam int CPB = 434;
`ifdef UART_RX_PARITY_EN
  localparam int PX = 1;
`else
  localparam int PX = 0;
`endif
  localparam int REF_LAT = 2 + CPB/2 + (9 + PX)*CPB + 1;

  logic       clk, rst, rx;
  logic [7:0] data;
  logic       new_data, frame_err, parity_err, busy;

  uart_rx_byte #(.CLK_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data(data), .new_data(new_data),
    .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {int kind; logic [7:0] b; int cyc;} ev_t;  // kind 1=byte 2=frame 3=parity
  ev_t act_q[$];
  ev_t exp_q[$];

  int   cyc = 0;
  int   n_tests = 0, n_fail = 0;
  int   multi = 0, consec = 0, gap = 0, bhi = 0;
  logic trk = 1'b0;
  logic prev_s = 1'b0;
  logic [7:0] model_data = 8'h00;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (new_data)   act_q.push_back('{kind: 1, b: data, cyc: cyc});
    if (frame_err)  act_q.push_back('{kind: 2, b: data, cyc: cyc});
    if (parity_err) act_q.push_back('{kind: 3, b: data, cyc: cyc});
    if (int'(new_data) + int'(frame_err) + int'(parity_err) > 1) multi++;
    if (prev_s && (new_data || frame_err || parity_err)) consec++;
    prev_s = new_data || frame_err || parity_err;
    if (trk && !busy) gap++;
    if (busy) bhi++;
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: stop low -> framing error; else bad even parity -> parity error; else byte.
  task automatic send(input logic [7:0] b, input logic p, input logic stop);
    int k;
    k = !stop ? 2 : ((PX == 1) && ((^b) ^ p)) ? 3 : 1;
    exp_q.push_back('{kind: k, b: b, cyc: cyc});
    drive(1'b0, 3);
    trk = 1'b1;
    drive(1'b0, CPB - 3);
    for (int i = 0; i < 8; i++) drive(b[i], CPB);
`ifdef UART_RX_PARITY_EN
    drive(p, CPB);
`endif
    trk = 1'b0;
    drive(stop, CPB);
  endtask

  task automatic compare(input string tag);
    ev_t a, e;
    chk({tag, "_nevents"}, act_q.size(), exp_q.size());
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_kind"}, a.kind, e.kind);
      chk({tag, "_lat"}, a.cyc - e.cyc, REF_LAT);
      if (e.kind == 1) begin
        chk({tag, "_byte"}, a.b, e.b);
        model_data = e.b;
      end
    end
    act_q.delete();
    exp_q.delete();
    chk({tag, "_data"}, data, model_data);
  endtask

  initial begin
    logic [7:0] b;
    logic       st, p;
    rst = 1'b0;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", data, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    drive(1'b1, 5000);
    chk("idle_busy_cycles", bhi, 0);
    compare("idle");

    send(8'h4F, 1'b1, 1'b1);
    drive(1'b1, 20);
    compare("f4f");
    chk("f4f_busy_gap", gap, 0);
    chk("f4f_busy_after", busy, 0);

    drive(1'b0, 100);
    drive(1'b1, CPB);
    compare("glitch");
    chk("glitch_busy", busy, 0);

    send(8'hA5, 1'b0, 1'b0);
    drive(1'b0, 3000);
    chk("ferr_busy_low", busy, 1);
    drive(1'b1, 10);
    chk("ferr_busy_high", busy, 0);
    compare("ferr");

    send(8'h00, 1'b0, 1'b1);
    send(8'hFF, 1'b0, 1'b1);
    send(8'h55, 1'b0, 1'b1);
    drive(1'b1, 20);
    compare("b2b");

`ifdef UART_RX_PARITY_EN
    send(8'h4F, 1'b1, 1'b1);
    drive(1'b1, 20);
    compare("par_ok");
    send(8'h4F, 1'b0, 1'b1);
    drive(1'b1, 20);
    compare("par_bad");
`endif

    for (int i = 0; i < 6; i++) begin
      b  = 8'($urandom);
      st = ($urandom_range(0, 4) != 0);
      p  = (^b) ^ ((PX == 1) && ($urandom_range(0, 3) == 0));
      send(b, p, st);
      drive(1'b1, st ? $urandom_range(0, 50) : CPB);
    end
    drive(1'b1, 20);
    compare("rand");

    // Asynchronous reset in the middle of a frame, checked before the next edge
    rx = 1'b0;
    repeat (300) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_data", data, 0);
    chk("arst_strobe", new_data, 0);
    model_data = 8'h00;
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    drive(1'b1, CPB);
    compare("arst");

    chk("strobe_multi", multi, 0);
    chk("strobe_consec", consec, 0);
    chk("busy_gap_total", gap, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
